// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side controller and its holding buffer.
package fifo_pkg;

  localparam int unsigned BUF_DEPTH     = 3;
  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned PTR_W         = 2;

  typedef logic [PTR_W-1:0] ptr_t;

  // Circular pointer advance over BUF_DEPTH entries: 0 -> 1 -> 2 -> 0.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(BUF_DEPTH - 1)) begin
      return '0;
    end
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Three-entry circular holding buffer between the FIFO read port and the output stream.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;

  // Next-state: write at wr_ptr, advance pointers, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (rd_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    occ_d = occ_q + {1'b0, wr_en} - {1'b0, rd_en};
  end

  // State registers; every entry clears so the idle output word reads as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign occ   = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: issues pops, captures registered FIFO data, streams it out valid/ready.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fifo_empty,
  input  logic             fifo_push_busy,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_pop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] pop_count
);

  logic [1:0]       occ;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] pop_count_q, pop_count_d;
  logic             acc;
  logic             rd_en;

  // Pop only when the word it returns is guaranteed a buffer slot; no path from m_ready.
  always_comb begin
    fifo_pop    = ~fifo_empty & (({1'b0, occ} + {2'b00, inflight_q}) <= 3'd2);
    // The FIFO gives its write side priority, so a pop during a push is dropped.
    acc         = fifo_pop & ~fifo_push_busy;
    inflight_d  = acc;
    pop_count_d = pop_count_q + CNT_W'(acc);
    m_valid     = (occ != 2'd0);
    rd_en       = m_valid & m_ready;
  end

  // In-flight flag and accepted-pop statistics counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q  <= 1'b0;
      pop_count_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      pop_count_q <= pop_count_d;
    end
  end

  fifo_rd_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk  (clk),
    .rstn (rstn),
    .wr_en(inflight_q),
    .wdata(fifo_dout),
    .rd_en(rd_en),
    .rdata(m_data),
    .occ  (occ)
  );

  assign pop_count = pop_count_q;

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the team's push/pop FIFO. It issues `pop` strobes, captures the FIFO's registered `dout` one cycle after each accepted pop, and presents the words on a valid/ready stream through a 3-entry holding buffer. It sustains one word per cycle when downstream is ready, and the FIFO write side never needs to know about backpressure. It sits between the FIFO instance and any consumer that speaks valid/ready.

## Interface

Parameters:
- `WIDTH`, 8, data word width; must match the FIFO's `WIDTH`.
- `CNT_W`, 16, width of the popped-word statistics counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_push_busy`  in  1  FIFO write side is pushing this cycle (writer `push & ~full`). The FIFO ignores a pop in such a cycle.
- `fifo_dout`  in  WIDTH  FIFO registered read data; valid the cycle after an accepted pop.
- `fifo_pop`  out  1  pop strobe to the FIFO.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  WIDTH  output word, the buffer head.
- `pop_count`  out  CNT_W  number of accepted pops since reset; wraps modulo 2^CNT_W.

## Operation

- State:
  - `occ` (0..3): buffer occupancy.
  - `inflight` (1 bit): a pop was accepted last cycle and its data is on `fifo_dout` now.
  - `wr_ptr` / `rd_ptr` (0..2): buffer pointers; each wraps from 2 to 0.
  - `pop_count`.
- `fifo_pop = ~fifo_empty & (occ + inflight <= 2)`. This is combinational from registered state and the FIFO's registered flag only, with no path from `m_ready`.
- Accepted pop: `acc = fifo_pop & ~fifo_push_busy`.
  - `inflight <= acc`.
  - `pop_count <= pop_count + acc`.
  - A rejected pop (push-priority collision) is not counted. It reasserts next cycle if its conditions still hold.
- Capture: when `inflight` is 1, write `fifo_dout` to `buf[wr_ptr]` and advance `wr_ptr`.
- Drain: `m_valid = (occ != 0)` and `m_data = buf[rd_ptr]`. On `m_valid & m_ready`, advance `rd_ptr`.
- `occ <= occ + inflight - (m_valid & m_ready)`. A capture and a drain in the same cycle leave `occ` unchanged.
- Overflow cannot occur: `occ + inflight <= 3` always holds. The bench asserts this invariant.
- Output order equals FIFO pop order. No word is dropped or duplicated.
- Reset (asynchronous, any time):
  - `occ`, `inflight`, pointers, `pop_count`, and all buffer entries go to 0.
  - Outputs: `fifo_pop` follows `~fifo_empty` (0 while the FIFO is itself in reset), `m_valid` 0, `m_data` 0, `pop_count` 0.
  - An in-flight word is discarded. The FIFO shares `rstn`, so its contents are cleared too.

## Timing

- Latency: pop accepted in cycle t → data on `fifo_dout` in t+1 → captured at the end of t+1 → `m_valid` in t+2.
- Throughput: with `m_ready` held at 1 and no push collisions, one word per cycle in steady state (`occ` = 1, `inflight` = 1).
- Backpressure:
  - With `m_ready` = 0, pops stop once `occ + inflight = 3`. At most 3 words are held.
  - When `m_ready` rises, words drain at 1/cycle. Pops resume the cycle after `occ + inflight` drops to 2 or below.
- `m_valid` and `m_data` stay stable while `m_valid & ~m_ready`.
- Empty boundary: a pop of the last FIFO word sets `fifo_empty` the next cycle, so no pop is issued on an empty FIFO. `fifo_pop` is never asserted while `fifo_empty` is 1.

## Structure

- Shared package `fifo_pkg`:
  - `BUF_DEPTH = 3`.
  - Default `WIDTH = 8`.
  - Pointer wrap function `ptr_inc`: 2 → 0.
- One sub-module, `fifo_rd_buf`: the 3-entry circular buffer with `wr_en`, `wdata`, `rd_en`, `rdata`, `occ`.
- The top level holds the pop/inflight/count logic.

## Test plan

- Streaming: FIFO preloaded with 0x11, 0x22, 0x33, 0x44; `m_ready` = 1 → pops in cycles 0–3; `m_data` 0x11..0x44 in cycles 2–5 with `m_valid` continuous; `pop_count` = 4.
- Backpressure: 6 words preloaded; `m_ready` = 0 → exactly 3 pops, `occ` = 3, `m_data` = word0 held. Raise `m_ready` → words 0–5 delivered in order with no gaps after the first.
- Push collision: `fifo_push_busy` = 1 in the cycle of a pop → no capture next cycle, `pop_count` unchanged, pop retried. Output sequence is still exact.
- Empty boundary: 1 word preloaded → exactly one `fifo_pop` pulse; `m_valid` for one cycle; `fifo_pop` stays 0 afterwards.
- Reset mid-stream: assert `rstn` = 0 with `occ` = 2 and `inflight` = 1 → `m_valid` = 0, `m_data` = 0, `pop_count` = 0 immediately. After release and a refill with 0xA5, the first output is 0xA5.
- Random soak: random pushes, `m_ready`, and collisions over 10k cycles → scoreboard shows in-order delivery and `occ + inflight <= 3` throughout.
